sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single-port tree/feature SRAM between NUM_MASTERS requesters (master 0 = Updater, master 1 = Searcher).
//  Round-robin grant with lock, bounded hold and per-master read-data return.
//  Sits between the octree engines and the sram instance; the SRAM side is a drop-in for the mem_sram_* bus.
// PARAMETERS
//  NUM_MASTERS     2   requesters, 2..4
//  DATA_BUS_WIDTH  64  SRAM D/Q width
//  ADDR_BUS_WIDTH  64  SRAM address width
//  MAX_HOLD        32  cycles a grant is held before an unlocked owner is preempted if another master waits
//  READ_LATENCY    1   cycles from read issue (CEN=0, GWEN=1) to valid mem_sram_Q, 1..2
// PORTS
//  clk            in   1                        clock
//  rst_n          in   1                        reset: synchronous, active-high (port name kept for codebase compatibility)
//  m_req          in   NUM_MASTERS              request; held for the whole transaction
//  m_lock         in   NUM_MASTERS              owner is in a read-modify-write; no preemption
//  m_gnt          out  NUM_MASTERS              one-hot grant (registered)
//  m_cen          in   NUM_MASTERS              per-master chip enable, active-low
//  m_gwen         in   NUM_MASTERS              per-master write enable, active-low
//  m_a            in   NUM_MASTERS*ADDR_BUS_WIDTH  per-master address
//  m_d            in   NUM_MASTERS*DATA_BUS_WIDTH  per-master write data
//  m_rvalid       out  NUM_MASTERS              read data valid for that master
//  m_rdata        out  DATA_BUS_WIDTH           read data, shared; qualified by m_rvalid
//  mem_sram_CEN   out  1                        SRAM chip enable, active-low
//  mem_sram_GWEN  out  1                        SRAM write enable, active-low
//  mem_sram_A     out  ADDR_BUS_WIDTH           SRAM address
//  mem_sram_D     out  DATA_BUS_WIDTH           SRAM write data
//  mem_sram_Q     in   DATA_BUS_WIDTH           SRAM read data
//  owner          out  $clog2(NUM_MASTERS)      current owner id; valid when busy
//  busy           out  1                        a grant is active
// BEHAVIOUR
//  Reset values: m_gnt=0, m_rvalid=0, busy=0, owner=0, rr pointer=0 (master 0 highest priority), hold_cnt=0, read tag pipe cleared.
//  FSM IDLE/GRANT:
//   - IDLE -> GRANT when any m_req is high. Winner is the first requester at or after rr_ptr. m_gnt rises the next cycle.
//   - In GRANT, when owner m_req falls at cycle t:
//       - if another m_req is high, its gnt is high at t+1 with no bubble; rr_ptr = old owner+1;
//       - otherwise go to IDLE.
//   - Preemption: when hold_cnt==MAX_HOLD-1 and the owner's m_lock is low and another master requests, grant moves to the next requester.
//     While m_lock is high, hold_cnt saturates and there is no preemption.
//  SRAM mux is combinational on the registered owner. Access is qualified by m_gnt[owner] & m_req[owner].
//   - Otherwise the SRAM side is idle: CEN=1, GWEN=1, A=0, D=0.
//   - Non-owner m_cen/m_gwen are ignored, so an ungranted access never reaches the SRAM.
//  Read return:
//   - A read issue (CEN=0, GWEN=1) pushes {owner, 1} into a READ_LATENCY-deep tag pipe.
//   - m_rvalid[tag] pulses READ_LATENCY cycles later with m_rdata=mem_sram_Q.
//   - This still holds after a grant change or handover: data goes to the issuer, not the new owner.
//  Writes (CEN=0, GWEN=0) produce no rvalid.
//  Reset mid-transaction: grant is dropped the next cycle and in-flight rvalids are discarded. Masters must restart.
//  m_req dropped without ever being granted: no effect and no grant.
// STRUCTURE
//  Package octree_mem_pkg holds:
//   - mst_id_t;
//   - MST_UPDATER=0, MST_SEARCHER=1;
//   - SRAM_CEN_ON=1'b0, SRAM_WR=1'b0;
//   - the mem_sram_* width constants.
//  One sub-module, rr_pick: combinational rotate-priority picker (req vector, ptr) -> one-hot + id. Instantiated once.
//  The FSM, hold counter, tag pipe and mux stay in the top module.
// TESTING
//  T1 single master: m_req[0]=1 at cycle 2 -> m_gnt=2'b01 at cycle 3.
//   - write A=5, D=64'hDEAD -> mem_sram_CEN=0, GWEN=0, A=5;
//   - read A=5 -> m_rvalid[0] one cycle later with m_rdata=64'hDEAD.
//  T2 simultaneous request after reset: m_req=2'b11 -> gnt 01.
//   - Drop req[0] -> gnt 10 the next cycle, no idle cycle.
//   - Re-request both -> master 0 wins (rr_ptr wrapped).
//  T3 ungranted access: master 1 drives CEN=0, A=9 while master 0 owns -> mem_sram_A follows master 0 and SRAM[9] is unchanged.
//  T4 preemption: master 0 holds req, lock=0, master 1 requests.
//   - With MAX_HOLD=32, gnt switches to 10 exactly 32 cycles after the first grant.
//   - Repeat with lock=1 -> no switch until lock falls.
//  T5 read across handover: master 0 issues a read at A=3 in its last granted cycle and drops req.
//   - m_rvalid[0] fires with SRAM[3]; m_rvalid[1] stays 0.
//  T6 reset mid-burst: assert rst_n (active-high) while gnt=01 with a read in flight.
//   - Next cycle: m_gnt=0, m_rvalid=0, mem_sram_CEN=1.

Source files
------------

// File: rtl/octree_mem_pkg.sv
// Shared types and constants for the octree SRAM port arbiter.
package octree_mem_pkg;

    // Width of the mem_sram_* bus
    localparam int unsigned SRAM_DATA_W = 64;
    localparam int unsigned SRAM_ADDR_W = 64;

    // Master ids are sized for the largest supported arbiter (4 masters)
    localparam int unsigned MST_ID_W    = 2;
    localparam int unsigned MAX_MASTERS = 4;

    typedef logic [MST_ID_W-1:0] mst_id_t;

    localparam mst_id_t MST_UPDATER  = 2'd0;
    localparam mst_id_t MST_SEARCHER = 2'd1;

    // SRAM control levels (active-low)
    localparam logic SRAM_CEN_ON = 1'b0;
    localparam logic SRAM_WR     = 1'b0;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

    // Next master id after id, wrapping at n
    function automatic mst_id_t next_id(input mst_id_t id, input int unsigned n);
        if (32'(id) + 32'd1 >= n) begin
            return '0;
        end
        return id + mst_id_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of i_req at or after i_ptr, wrapping.
module rr_pick
    import octree_mem_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0] i_req,
    input  mst_id_t      i_ptr,
    output logic [N-1:0] o_gnt,
    output mst_id_t      o_id,
    output logic         o_valid
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;

    // Rotate the request vector so i_ptr lands at bit 0, then take the lowest set bit
    always_comb begin
        w_dbl   = {i_req, i_req} >> i_ptr;
        w_rot   = w_dbl[N-1:0];
        o_gnt   = '0;
        o_id    = '0;
        o_valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!o_valid && w_rot[j]) begin
                o_valid = 1'b1;
                o_id    = mst_id_t'((32'(i_ptr) + 32'(j)) % N);
            end
        end
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = o_valid && (o_id == mst_id_t'(i));
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_MASTERS engines,
// with lock, bounded hold and read data routed back to the issuing master.
module sram_port_arbiter
    import octree_mem_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned DATA_BUS_WIDTH = SRAM_DATA_W,
    parameter int unsigned ADDR_BUS_WIDTH = SRAM_ADDR_W,
    parameter int unsigned MAX_HOLD       = 32,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_MASTERS-1:0]                 m_req,
    input  logic [NUM_MASTERS-1:0]                 m_lock,
    output logic [NUM_MASTERS-1:0]                 m_gnt,
    input  logic [NUM_MASTERS-1:0]                 m_cen,
    input  logic [NUM_MASTERS-1:0]                 m_gwen,
    input  logic [NUM_MASTERS*ADDR_BUS_WIDTH-1:0]  m_a,
    input  logic [NUM_MASTERS*DATA_BUS_WIDTH-1:0]  m_d,
    output logic [NUM_MASTERS-1:0]                 m_rvalid,
    output logic [DATA_BUS_WIDTH-1:0]              m_rdata,
    output logic                                   mem_sram_CEN,
    output logic                                   mem_sram_GWEN,
    output logic [ADDR_BUS_WIDTH-1:0]              mem_sram_A,
    output logic [DATA_BUS_WIDTH-1:0]              mem_sram_D,
    input  logic [DATA_BUS_WIDTH-1:0]              mem_sram_Q,
    output logic [$clog2(NUM_MASTERS)-1:0]         owner,
    output logic                                   busy
);

    localparam int unsigned IdW   = $clog2(NUM_MASTERS);
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

    arb_state_e             r_state;
    logic [NUM_MASTERS-1:0] r_gnt;
    mst_id_t                r_owner;
    mst_id_t                r_rr_ptr;
    logic [HoldW-1:0]       r_hold_cnt;
    logic                   r_tag_v  [READ_LATENCY];
    mst_id_t                r_tag_id [READ_LATENCY];

    arb_state_e             w_state_nxt;
    logic [NUM_MASTERS-1:0] w_gnt_nxt;
    mst_id_t                w_owner_nxt;
    mst_id_t                w_rr_nxt;
    logic [HoldW-1:0]       w_hold_nxt;

    logic                   w_owner_req;
    logic                   w_owner_lock;
    logic                   w_hold_max;
    logic                   w_acc;
    logic                   w_rd_issue;
    mst_id_t                w_pick_ptr;
    logic [NUM_MASTERS-1:0] w_pick_oh;
    mst_id_t                w_pick_id;
    logic                   w_pick_valid;

    assign w_owner_req  = |(m_req & r_gnt);
    assign w_owner_lock = |(m_lock & r_gnt);
    assign w_hold_max   = (r_hold_cnt == HoldW'(MAX_HOLD - 1));
    // While granted, the search for a successor starts just after the owner
    assign w_pick_ptr   = (r_state == StGrant) ? next_id(r_owner, NUM_MASTERS) : r_rr_ptr;

    rr_pick #(
        .N (NUM_MASTERS)
    ) u_rr_pick (
        .i_req   (m_req & ~r_gnt),
        .i_ptr   (w_pick_ptr),
        .o_gnt   (w_pick_oh),
        .o_id    (w_pick_id),
        .o_valid (w_pick_valid)
    );

    // FSM state, grant, round-robin pointer and hold counter registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= StIdle;
            r_gnt      <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Next-state: grant from idle, hand over on release, preempt after a full unlocked hold
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_hold_nxt  = r_hold_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_state_nxt = StGrant;
                    w_gnt_nxt   = w_pick_oh;
                    w_owner_nxt = w_pick_id;
                    w_hold_nxt  = '0;
                end
            end
            StGrant: begin
                if (!w_owner_req) begin
                    w_rr_nxt   = next_id(r_owner, NUM_MASTERS);
                    w_hold_nxt = '0;
                    if (w_pick_valid) begin
                        w_gnt_nxt   = w_pick_oh;
                        w_owner_nxt = w_pick_id;
                    end else begin
                        w_state_nxt = StIdle;
                        w_gnt_nxt   = '0;
                    end
                end else if (w_hold_max && !w_owner_lock && w_pick_valid) begin
                    w_rr_nxt    = next_id(r_owner, NUM_MASTERS);
                    w_hold_nxt  = '0;
                    w_gnt_nxt   = w_pick_oh;
                    w_owner_nxt = w_pick_id;
                end else if (!w_hold_max) begin
                    // Saturates at MAX_HOLD-1 so a lock release preempts immediately
                    w_hold_nxt = r_hold_cnt + HoldW'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // SRAM mux: only a granted master that still requests reaches the SRAM
    always_comb begin
        mem_sram_CEN  = ~SRAM_CEN_ON;
        mem_sram_GWEN = ~SRAM_WR;
        mem_sram_A    = '0;
        mem_sram_D    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_gnt[i] && m_req[i]) begin
                mem_sram_CEN  = m_cen[i];
                mem_sram_GWEN = m_gwen[i];
                mem_sram_A    = m_a[i*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
                mem_sram_D    = m_d[i*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
            end
        end
    end

    assign w_acc      = |(r_gnt & m_req);
    assign w_rd_issue = w_acc && (mem_sram_CEN == SRAM_CEN_ON) && (mem_sram_GWEN != SRAM_WR);

    // Read tag pipe: carries the issuer id so data survives a grant change
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag_v[i]  <= 1'b0;
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_rd_issue;
            r_tag_id[0] <= r_owner;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    // Return read valid to the master recorded in the last tag stage
    always_comb begin
        m_rvalid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_rvalid[i] = r_tag_v[READ_LATENCY-1] && (r_tag_id[READ_LATENCY-1] == mst_id_t'(i));
        end
    end

    assign m_rdata = mem_sram_Q;
    assign m_gnt   = r_gnt;
    assign busy    = (r_state == StGrant);
    assign owner   = r_owner[IdW-1:0];

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small behavioural SRAM.
module tb_sram_port_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_req, m_lock, m_gnt, m_cen, m_gwen, m_rvalid;
    logic [N*AW-1:0] m_a;
    logic [N*DW-1:0] m_d;
    logic [DW-1:0]   m_rdata;
    logic            mem_sram_CEN, mem_sram_GWEN;
    logic [AW-1:0]   mem_sram_A;
    logic [DW-1:0]   mem_sram_D;
    logic [DW-1:0]   mem_sram_Q;
    logic            owner;
    logic            busy;
    logic            tb_init;

    int n_checks = 0;
    int n_errors = 0;

    sram_port_arbiter #(
        .NUM_MASTERS    (N),
        .DATA_BUS_WIDTH (DW),
        .ADDR_BUS_WIDTH (AW),
        .MAX_HOLD       (32),
        .READ_LATENCY   (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_req         (m_req),
        .m_lock        (m_lock),
        .m_gnt         (m_gnt),
        .m_cen         (m_cen),
        .m_gwen        (m_gwen),
        .m_a           (m_a),
        .m_d           (m_d),
        .m_rvalid      (m_rvalid),
        .m_rdata       (m_rdata),
        .mem_sram_CEN  (mem_sram_CEN),
        .mem_sram_GWEN (mem_sram_GWEN),
        .mem_sram_A    (mem_sram_A),
        .mem_sram_D    (mem_sram_D),
        .mem_sram_Q    (mem_sram_Q),
        .owner         (owner),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // 16-word SRAM, one-cycle read latency; word i starts as 'h1000+i
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 64'h1000 + 64'(i);
        end else if (mem_sram_CEN == 1'b0) begin
            if (mem_sram_GWEN == 1'b0) mem[mem_sram_A[3:0]] <= mem_sram_D;
            else mem_sram_Q <= mem[mem_sram_A[3:0]];
        end
    end

    typedef struct {
        logic        rst;
        logic [1:0]  req, cen, gwen;
        logic [7:0]  a0, a1;
        logic [15:0] d0, d1;
        logic [1:0]  e_gnt;
        logic        e_busy, e_own, e_cen, e_gwen;
        logic [7:0]  e_a;
        logic [15:0] e_d;
        logic [1:0]  e_rv;
        logic [15:0] e_rd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int rst, req, cen, gwen, a0, a1, d0, d1,
                                input int eg, eb, eo, ec, ew, ea, ed, erv, erd);
        vec_t v;
        v.rst = 1'(rst);  v.req = 2'(req);  v.cen = 2'(cen);  v.gwen = 2'(gwen);
        v.a0 = 8'(a0);    v.a1 = 8'(a1);    v.d0 = 16'(d0);   v.d1 = 16'(d1);
        v.e_gnt = 2'(eg); v.e_busy = 1'(eb); v.e_own = 1'(eo);
        v.e_cen = 1'(ec); v.e_gwen = 1'(ew); v.e_a = 8'(ea);  v.e_d = 16'(ed);
        v.e_rv = 2'(erv); v.e_rd = 16'(erd);
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [63:0] act, exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n  = v.rst;
        m_req  = v.req;
        m_lock = 2'b00;
        m_cen  = v.cen;
        m_gwen = v.gwen;
        m_a    = {56'd0, v.a1, 56'd0, v.a0};
        m_d    = {48'd0, v.d1, 48'd0, v.d0};
    endtask

    task automatic idle_inputs();
        m_req = 2'b00; m_lock = 2'b00; m_cen = 2'b11; m_gwen = 2'b11; m_a = '0; m_d = '0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b0;
    endtask

    // Returns the first cycle (0 = first grant cycle) at which master 0 loses the grant;
    // master 0 reads address 3 at cycle 31, lock held until lock_until
    task automatic hold_run(input int lock_until, output int sw);
        sw = -1;
        for (int k = 0; k < 64; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            m_req  = 2'b11;
            m_lock = (k < lock_until) ? 2'b01 : 2'b00;
            if (k == 31) begin m_cen = 2'b10; m_gwen = 2'b11; m_a = 128'd3; end
            else begin m_cen = 2'b11; m_gwen = 2'b11; m_a = '0; end
            @(negedge clk);
            if (m_gnt !== 2'b01) begin sw = k; break; end
        end
    endtask

    initial begin
        int sw;
        // rst, req, cen, gwen, a0, a1, d0, d1 | gnt, busy, own, CEN, GWEN, A, D, rvalid, rdata
        vq.push_back(mk(1, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b01, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b01, 'b10, 'b10, 5, 0, 'hDEAD, 0,      'b01, 1, 0, 0, 0, 5, 'hDEAD, 'b00, 0));
        vq.push_back(mk(0, 'b01, 'b10, 'b11, 5, 0, 0, 0,           'b01, 1, 0, 0, 1, 5, 0, 'b00, 0));
        vq.push_back(mk(0, 'b01, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b01, 'hDEAD));
        vq.push_back(mk(0, 'b01, 'b01, 'b01, 7, 9, 0, 'hBEEF,      'b01, 1, 0, 1, 1, 7, 0, 'b00, 0));
        vq.push_back(mk(0, 'b01, 'b10, 'b11, 9, 0, 0, 0,           'b01, 1, 0, 0, 1, 9, 0, 'b00, 0));
        vq.push_back(mk(0, 'b01, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b01, 'h1009));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(1, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b11, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b11, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b10, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b10, 'b11, 'b11, 0, 0, 0, 0,           'b10, 1, 1, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b10, 1, 1, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b11, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b11, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b11, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b11, 'b11, 'b11, 0, 0, 0, 0,           'b10, 1, 1, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b10, 1, 1, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b11, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b11, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b11, 'b10, 'b11, 3, 0, 0, 0,           'b01, 1, 0, 0, 1, 3, 0, 'b00, 0));
        vq.push_back(mk(0, 'b10, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b01, 'h1003));
        vq.push_back(mk(0, 'b10, 'b01, 'b01, 0, 12, 0, 'hBEEF,     'b10, 1, 1, 0, 0, 12, 'hBEEF, 'b00, 0));
        vq.push_back(mk(0, 'b10, 'b11, 'b11, 0, 0, 0, 0,           'b10, 1, 1, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b10, 'b01, 'b11, 0, 12, 0, 0,          'b10, 1, 1, 0, 1, 12, 0, 'b00, 0));
        vq.push_back(mk(0, 'b10, 'b11, 'b11, 0, 0, 0, 0,           'b10, 1, 1, 1, 1, 0, 0, 'b10, 'hBEEF));
        vq.push_back(mk(0, 'b01, 'b11, 'b11, 0, 0, 0, 0,           'b10, 1, 1, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b01, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b01, 'b10, 'b11, 5, 0, 0, 0,           'b01, 1, 0, 0, 1, 5, 0, 'b00, 0));
        vq.push_back(mk(1, 'b01, 'b10, 'b11, 5, 0, 0, 0,           'b01, 1, 0, 0, 1, 5, 0, 'b01, 'hDEAD));
        vq.push_back(mk(0, 'b01, 'b10, 'b11, 5, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b01, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b11, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b01, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b01, 1, 0, 1, 1, 0, 0, 'b00, 0));
        vq.push_back(mk(0, 'b00, 'b11, 'b11, 0, 0, 0, 0,           'b00, 0, 0, 1, 1, 0, 0, 'b00, 0));

        // Power-up: reset the DUT and load the SRAM model
        rst_n   = 1'b1;
        tb_init = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 tb_init = 1'b0;

        for (int r = 0; r < vq.size(); r++) begin
            @(posedge clk); #1;
            drive(vq[r]);
            @(negedge clk);
            chk("gnt",    r, 64'(m_gnt),         64'(vq[r].e_gnt));
            chk("busy",   r, 64'(busy),          64'(vq[r].e_busy));
            if (vq[r].e_busy) chk("owner", r, 64'(owner), 64'(vq[r].e_own));
            chk("cen",    r, 64'(mem_sram_CEN),  64'(vq[r].e_cen));
            chk("gwen",   r, 64'(mem_sram_GWEN), 64'(vq[r].e_gwen));
            chk("addr",   r, mem_sram_A,         64'(vq[r].e_a));
            chk("wdata",  r, mem_sram_D,         64'(vq[r].e_d));
            chk("rvalid", r, 64'(m_rvalid),      64'(vq[r].e_rv));
            if (vq[r].e_rv != 2'b00) chk("rdata", r, m_rdata, 64'(vq[r].e_rd));
        end

        // Unlocked owner is preempted 32 cycles after its first grant; its last read still
        // returns to it after the handover
        reset_dut();
        m_req = 2'b01;
        @(posedge clk); #1;
        hold_run(0, sw);
        chk("preempt_cycle",  0, 64'(sw),       64'd32);
        chk("preempt_gnt",    0, 64'(m_gnt),    64'b10);
        chk("preempt_owner",  0, 64'(owner),    64'd1);
        chk("handover_rv",    0, 64'(m_rvalid), 64'b01);
        chk("handover_rdata", 0, m_rdata,       64'h1003);

        // Locked owner keeps the grant until the lock falls at cycle 40
        reset_dut();
        m_req  = 2'b01;
        m_lock = 2'b01;
        @(posedge clk); #1;
        hold_run(40, sw);
        chk("lock_cycle", 1, 64'(sw),    64'd41);
        chk("lock_gnt",   1, 64'(m_gnt), 64'b10);
        chk("lock_busy",  1, 64'(busy),  64'd1);

        @(posedge clk); #1;
        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
